// File: rtl/wit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wit_pkg
//  Description : Shared constants for the wrap interval timer: FSM state
//                encoding and the width of the upstream count.
//  Revision    : 1.0 - initial release
// ============================================================================
package wit_pkg;

   // Width of the upstream down-counter value
   localparam int CNT_W = 4;

   // FSM state encoding (ERR is only reachable when the stall timeout is built in)
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;
   localparam logic [1:0] ERR  = 2'd3;

   // Value the upstream counter shows right after it wraps from zero
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

endpackage : wit_pkg
`default_nettype wire

// File: rtl/wit_wrap_detect.sv
`default_nettype none
// ============================================================================
//  Module      : wit_wrap_detect
//  Description : Remembers the previous upstream count and flags the cycle in
//                which the down counter wraps from 0 to its maximum value.
//                The previous value is only trusted once one post-reset cycle
//                has been captured, so a count that already sits at the
//                maximum when reset releases is never taken as a wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module wit_wrap_detect
   import wit_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [CNT_W-1:0] i_cnt,
   output logic [CNT_W-1:0] o_prev_cnt,
   output logic             o_wrap
);

   logic [CNT_W-1:0] r_prev_cnt;
   logic             r_prev_vld;

   // Capture the upstream count every cycle; validity follows one cycle after reset
   always_ff @(posedge clk) begin
      if (rst) begin
         r_prev_cnt <= '0;
         r_prev_vld <= 1'b0;
      end else begin
         r_prev_cnt <= i_cnt;
         r_prev_vld <= 1'b1;
      end
   end

   // A wrap is strictly the 0 -> max step; any other jump to max is ignored
   assign o_wrap     = r_prev_vld && (r_prev_cnt == '0) && (i_cnt == CNT_MAX);
   assign o_prev_cnt = r_prev_cnt;

endmodule : wit_wrap_detect
`default_nettype wire

// File: rtl/wrap_interval_timer.sv
`default_nettype none
// ============================================================================
//  Module      : wrap_interval_timer
//  Description : Counts a programmable number of wraps of an upstream 4-bit
//                down counter and raises done, held until acknowledged.
//                Stretches the 16-cycle counter period into long intervals.
//  Options     : WIT_STALL_TIMEOUT_EN - when defined, a frozen upstream count
//                during RUN for TO_CYC cycles moves the timer into ERR.
//                When undefined there is no ERR state and err is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module wrap_interval_timer
   import wit_pkg::*;
#(
   parameter int PW     = 8,
   parameter int TO_CYC = 32
)(
   input  logic             clk,
   input  logic             rst,
   input  logic [CNT_W-1:0] cnt_in,
   input  logic             start,
   input  logic [PW-1:0]    period,
   input  logic             ack,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [PW-1:0]    remaining
);

   localparam logic [PW-1:0] c_ONE = PW'(1);

   logic [1:0]       r_state;
   logic [PW-1:0]    r_remaining;
   logic             w_wrap;
   logic [CNT_W-1:0] w_prev_cnt;
   logic             w_stall_hit;

   wit_wrap_detect u_wrap_detect (
      .clk        (clk),
      .rst        (rst),
      .i_cnt      (cnt_in),
      .o_prev_cnt (w_prev_cnt),
      .o_wrap     (w_wrap)
   );

`ifdef WIT_STALL_TIMEOUT_EN
   localparam int STALL_W = $clog2(TO_CYC + 1);
   localparam logic [STALL_W-1:0] c_STALL_LAST = STALL_W'(TO_CYC - 1);

   logic [STALL_W-1:0] r_stall;
   logic               w_hold;

   // Upstream count did not move since the previous cycle
   assign w_hold = (cnt_in == w_prev_cnt);

   // Count consecutive frozen cycles while running; any movement or leaving RUN clears it
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall <= '0;
      end else if ((r_state == RUN) && w_hold && !w_stall_hit) begin
         r_stall <= r_stall + STALL_W'(1);
      end else begin
         r_stall <= '0;
      end
   end

   // The frozen cycle that brings the count up to TO_CYC triggers the timeout
   assign w_stall_hit = (r_state == RUN) && w_hold && (r_stall == c_STALL_LAST);
`else
   logic w_unused;

   // Stall supervision is not built: previous count and timeout limit are not needed
   assign w_stall_hit = 1'b0;
   assign w_unused    = ^{w_prev_cnt, (TO_CYC != 0)};
`endif

   // Main control: accept start in IDLE, count wraps in RUN, hold DONE/ERR until ack
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_remaining <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  if (period == '0) begin
                     // Zero-length interval completes immediately without a RUN cycle
                     r_state <= DONE;
                  end else begin
                     r_state     <= RUN;
                     r_remaining <= period;
                  end
               end
            end
            RUN: begin
               if (w_wrap) begin
                  if (r_remaining == c_ONE) begin
                     r_state     <= DONE;
                     r_remaining <= '0;
                  end else begin
                     r_remaining <= r_remaining - c_ONE;
                  end
               end else if (w_stall_hit) begin
                  r_state     <= ERR;
                  r_remaining <= '0;
               end
            end
            DONE: begin
               // A simultaneous start is deliberately dropped here
               if (ack) begin
                  r_state <= IDLE;
               end
            end
`ifdef WIT_STALL_TIMEOUT_EN
            ERR: begin
               if (ack) begin
                  r_state <= IDLE;
               end
            end
`endif
            default: begin
               r_state     <= IDLE;
               r_remaining <= '0;
            end
         endcase
      end
   end

   assign busy      = (r_state == RUN);
   assign done      = (r_state == DONE);
`ifdef WIT_STALL_TIMEOUT_EN
   assign err       = (r_state == ERR);
`else
   assign err       = 1'b0;
`endif
   assign remaining = r_remaining;

endmodule : wrap_interval_timer
`default_nettype wire

// File: tb/tb_wrap_interval_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wrap_interval_timer
//  Description : Self-checking bench for wrap_interval_timer with a
//                behavioural reference model of the interval timer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wrap_interval_timer;

   localparam int PW     = 8;
   localparam int TO_CYC = 32;

   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_DONE = 2;
   localparam int M_ERR  = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic [3:0]    cnt_in;
   logic          start;
   logic [PW-1:0] period;
   logic          ack;
   logic          busy;
   logic          done;
   logic          err;
   logic [PW-1:0] remaining;

   int checks   = 0;
   int failures = 0;

   // reference model state
   int m_mode;
   int m_left;
   int m_prev;
   int m_stall;
   bit m_vld;
   bit free_run;

   wrap_interval_timer #(.PW(PW), .TO_CYC(TO_CYC)) dut (
      .clk       (clk),
      .rst       (rst),
      .cnt_in    (cnt_in),
      .start     (start),
      .period    (period),
      .ack       (ack),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .remaining (remaining)
   );

   always #5 clk = ~clk;

   function automatic logic [PW+2:0] model_out();
      return {m_mode == M_RUN, m_mode == M_DONE, m_mode == M_ERR, PW'(m_left)};
   endfunction

   // One clock edge: model consumes the inputs present at the edge, then the
   // upstream counter (if free running) steps down just after the edge.
   task automatic tick();
      int  nmode  = m_mode;
      int  nleft  = m_left;
      int  nstall = m_stall;
      bit  wrap;
      bit  hold;
      wrap = m_vld && (m_prev == 0) && (cnt_in == 4'hF);
      hold = (int'(cnt_in) == m_prev);
      if (rst) begin
         nmode = M_IDLE; nleft = 0; nstall = 0;
      end else begin
         case (m_mode)
            M_IDLE: if (start) begin
               if (period == 0) nmode = M_DONE;
               else begin nmode = M_RUN; nleft = int'(period); end
            end
            M_RUN: begin
               nstall = hold ? m_stall + 1 : 0;
               if (wrap) begin
                  if (m_left == 1) begin nmode = M_DONE; nleft = 0; end
                  else nleft = m_left - 1;
               end
`ifdef WIT_STALL_TIMEOUT_EN
               else if (nstall == TO_CYC) begin nmode = M_ERR; nleft = 0; end
`endif
               if (nmode != M_RUN) nstall = 0;
            end
            default: if (ack) nmode = M_IDLE;
         endcase
      end
      @(posedge clk);
      #1;
      m_mode = nmode; m_left = nleft; m_stall = nstall;
      if (rst) begin m_prev = 0; m_vld = 0; end
      else begin m_prev = int'(cnt_in); m_vld = 1; end
      if (free_run) cnt_in = cnt_in - 4'd1;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; ack = 1'b0; free_run = 1'b0;
      period = PW'($urandom); cnt_in = 4'($urandom);
      tick(); tick();
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
      checks++; if (remaining !== '0) begin failures++; $display("FAIL reset_remaining got=%0d exp=0", remaining); end
   endtask

   task automatic test_period3();
      int seq[$];
      int n;
      rst = 1'b0; free_run = 1'b1; cnt_in = 4'($urandom);
      n = $urandom_range(0, 20);
      for (int i = 0; i < n; i++) tick();
      period = 8'd3; start = 1'b1;
      tick();
      start = 1'b0; period = PW'($urandom_range(5, 200));
      seq.push_back(int'(remaining));
      for (int i = 0; i < 100 && done !== 1'b1; i++) begin
         tick();
         checks++;
         if ({busy, done, err, remaining} !== model_out()) begin
            failures++;
            $display("FAIL period3_cycle got=%h exp=%h", {busy, done, err, remaining}, model_out());
         end
         if (int'(remaining) != seq[$]) seq.push_back(int'(remaining));
      end
      checks++; if (done !== 1'b1) begin failures++; $display("FAIL period3_done got=%b exp=1", done); end
      checks++;
      if (seq.size() != 4 || seq[0] != 3 || seq[1] != 2 || seq[2] != 1 || seq[3] != 0) begin
         failures++;
         $display("FAIL period3_sequence got=%p exp='{3,2,1,0}", seq);
      end
      ack = 1'b1; tick(); ack = 1'b0;
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL period3_ack got done=%b busy=%b exp 0/0", done, busy); end
   endtask

   task automatic test_period_zero();
      free_run = 1'b1;
      period = '0; start = 1'b1;
      tick();
      start = 1'b0;
      checks++; if (done !== 1'b1) begin failures++; $display("FAIL pzero_done got=%b exp=1", done); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL pzero_busy got=%b exp=0", busy); end
      ack = 1'b1; tick(); ack = 1'b0;
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL pzero_ack got=%b exp=0", done); end
   endtask

   task automatic test_no_false_wrap();
      free_run = 1'b0; rst = 1'b1; cnt_in = 4'hF;
      tick(); tick();
      rst = 1'b0;
      tick();
      period = 8'd2; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (remaining !== 8'd2 || busy !== 1'b1) begin
            failures++;
            $display("FAIL nofalse_hold got rem=%0d busy=%b exp rem=2 busy=1", remaining, busy);
         end
      end
      cnt_in = 4'h1; tick();
      cnt_in = 4'hF; tick();
      checks++; if (remaining !== 8'd2) begin failures++; $display("FAIL nofalse_jump got=%0d exp=2", remaining); end
      cnt_in = 4'h0; tick();
      cnt_in = 4'hF; tick();
      checks++; if (remaining !== 8'd1) begin failures++; $display("FAIL nofalse_realwrap got=%0d exp=1", remaining); end
      rst = 1'b1; tick(); rst = 1'b0;
   endtask

   task automatic test_reset_mid_run();
      int guard = 0;
      free_run = 1'b1; period = 8'd5; start = 1'b1;
      tick();
      start = 1'b0;
      while (remaining !== 8'd2 && guard < 200) begin tick(); guard++; end
      checks++; if (guard >= 200) begin failures++; $display("FAIL midrun_reach got=%0d exp=2", remaining); end
      rst = 1'b1; tick(); rst = 1'b0;
      checks++; if (busy !== 1'b0 || remaining !== '0) begin failures++; $display("FAIL midrun_abort got busy=%b rem=%0d exp 0/0", busy, remaining); end
      for (int i = 0; i < 40; i++) begin
         tick();
         checks++; if (done !== 1'b0) begin failures++; $display("FAIL midrun_nodone got=%b exp=0", done); end
      end
   endtask

   task automatic test_start_ack_done();
      int guard = 0;
      free_run = 1'b1; period = '0; start = 1'b1;
      tick();
      period = 8'd1; ack = 1'b1;
      tick();
      start = 1'b0; ack = 1'b0;
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL startack_idle got done=%b busy=%b exp 0/0", done, busy); end
      tick();
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL startack_stay got=%b exp=0", busy); end
      start = 1'b1; tick(); start = 1'b0;
      checks++; if (busy !== 1'b1 || remaining !== 8'd1) begin failures++; $display("FAIL startack_restart got busy=%b rem=%0d exp 1/1", busy, remaining); end
      while (done !== 1'b1 && guard < 40) begin
         tick(); guard++;
         checks++;
         if ({busy, done, err, remaining} !== model_out()) begin
            failures++;
            $display("FAIL startack_cycle got=%h exp=%h", {busy, done, err, remaining}, model_out());
         end
      end
      checks++; if (done !== 1'b1) begin failures++; $display("FAIL startack_done got=%b exp=1", done); end
      ack = 1'b1; tick(); ack = 1'b0;
   endtask

   task automatic test_random();
      int r;
      free_run = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         r = $urandom_range(0, 99);
         if (r < 85)      cnt_in = cnt_in - 4'd1;
         else if (r < 90) cnt_in = 4'($urandom);
         start  = ($urandom_range(0, 9) < 3);
         period = PW'($urandom_range(0, 4));
         ack    = ($urandom_range(0, 9) < 3);
         rst    = ($urandom_range(0, 299) == 0);
         tick();
         checks++;
         if ({busy, done, err, remaining} !== model_out()) begin
            failures++;
            $display("FAIL random_cycle%0d got=%h exp=%h", i, {busy, done, err, remaining}, model_out());
         end
      end
      start = 1'b0; ack = 1'b0; rst = 1'b1; tick(); rst = 1'b0;
   endtask

   task automatic test_stall();
      free_run = 1'b1; period = 8'd2; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      free_run = 1'b0; cnt_in = 4'h7;
      for (int i = 0; i < TO_CYC + 8; i++) begin
         tick();
         checks++;
         if ({busy, done, err, remaining} !== model_out()) begin
            failures++;
            $display("FAIL stall_cycle got=%h exp=%h", {busy, done, err, remaining}, model_out());
         end
      end
`ifdef WIT_STALL_TIMEOUT_EN
      checks++; if (err !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL stall_err got err=%b busy=%b exp 1/0", err, busy); end
      ack = 1'b1; tick(); ack = 1'b0;
      checks++; if (err !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL stall_ack got err=%b busy=%b exp 0/0", err, busy); end
`else
      checks++; if (err !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL stall_noerr got err=%b busy=%b exp 0/1", err, busy); end
`endif
   endtask

   initial begin
      m_mode = M_IDLE; m_left = 0; m_prev = 0; m_stall = 0; m_vld = 1'b0;
      free_run = 1'b0;
      rst = 1'b1; start = 1'b0; ack = 1'b0; period = '0; cnt_in = '0;
      test_reset();
      test_period3();
      test_period_zero();
      test_no_false_wrap();
      test_reset_mid_run();
      test_start_ack_done();
      test_random();
      test_stall();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_wrap_interval_timer
`default_nettype wire
